ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one byte (e.g. LED command 0xED, set-LED argument, 0xF4 enable) from the FPGA to the attached keyboard using the PS/2 request-to-send sequence, device-generated clock, odd parity, and device acknowledge. Sits beside the existing ps2key receiver on the same ps2_key_clk/ps2_key_data pins, which are driven open-drain at the top level from this block's output-enable signals.

---
 rtl/ps2_host_tx_if.sv | 25 ++
 rtl/ps2_host_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Handshake and PS/2 line sense/drive bundle for ps2_host_tx.
// slave = transmitter side, master = user logic plus pin model.
interface ps2_host_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             tx_done;
  logic             tx_err;
  logic             ps2_key_clk;
  logic             ps2_key_data;
  logic             ps2_clk_oe;
  logic             ps2_data_oe;

  modport master (
    output tx_data, tx_start, ps2_key_clk, ps2_key_data,
    input  tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_start, ps2_key_clk, ps2_key_data,
    output tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter (request-to-send, odd parity, device ACK).
// Define PS2_TX_FILTER_EN to add an 8-sample glitch filter on the synchronized clock.
module ps2_host_tx #(
  parameter int WIDTH       = 8,
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input logic          sys_clk,
  input logic          sys_rst_n,
  ps2_host_tx_if.slave bus
);

  localparam int MAX_CYC = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] START_AT     = CNT_W'(INHIBIT_CYC - 2);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       LAST_BIT     = 4'(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       bit_idx, bit_nxt;
  logic [WIDTH:0]   shift, shift_nxt;
  logic             data_oe_q, data_oe_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_lvl;
  logic       clk_prev;
  logic       data_lvl;
  logic       fall;
  logic       timed_out;

  // Lines idle high, so synchronizers reset to 1 to avoid a false edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], bus.ps2_key_clk};
      data_sync <= {data_sync[0], bus.ps2_key_data};
    end
  end

  assign data_lvl = data_sync[1];

`ifdef PS2_TX_FILTER_EN
  logic [2:0] filt_cnt;
  logic       clk_filt;

  // Level follows the synchronized clock only after 8 consecutive differing samples
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      filt_cnt <= 3'd0;
      clk_filt <= 1'b1;
    end else if (clk_sync[1] == clk_filt) begin
      filt_cnt <= 3'd0;
    end else if (filt_cnt == 3'd7) begin
      filt_cnt <= 3'd0;
      clk_filt <= clk_sync[1];
    end else begin
      filt_cnt <= filt_cnt + 3'd1;
    end
  end

  assign clk_lvl = clk_filt;
`else
  assign clk_lvl = clk_sync[1];
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_prev <= 1'b1;
    end else begin
      clk_prev <= clk_lvl;
    end
  end

  assign fall      = clk_prev & ~clk_lvl;
  assign timed_out = (cnt == TIMEOUT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 4'd0;
      shift     <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      shift     <= shift_nxt;
      data_oe_q <= data_oe_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  // bit_idx counts device falling edges already serviced; edge 10 releases for the stop bit
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    bit_nxt     = bit_idx;
    shift_nxt   = shift;
    data_oe_nxt = data_oe_q;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        data_oe_nxt = 1'b0;
        if (bus.tx_start) begin
          shift_nxt = {~^bus.tx_data, bus.tx_data};
          bit_nxt   = 4'd0;
          state_nxt = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt == START_AT) begin
          data_oe_nxt = 1'b1;
        end
        if (cnt == INHIBIT_LAST) begin
          data_oe_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = REQ;
        end
      end

      REQ: begin
        if (fall) begin
          data_oe_nxt = ~shift[0];
          shift_nxt   = {1'b0, shift[WIDTH:1]};
          bit_nxt     = 4'd1;
          cnt_nxt     = '0;
          state_nxt   = SHIFT;
        end else if (timed_out) begin
          data_oe_nxt = 1'b0;
          err_nxt     = 1'b1;
          state_nxt   = IDLE;
        end
      end

      SHIFT: begin
        if (fall) begin
          cnt_nxt = '0;
          if (bit_idx == LAST_BIT) begin
            data_oe_nxt = 1'b0;
            state_nxt   = ACK;
          end else begin
            data_oe_nxt = ~shift[0];
            shift_nxt   = {1'b0, shift[WIDTH:1]};
            bit_nxt     = bit_idx + 4'd1;
          end
        end else if (timed_out) begin
          data_oe_nxt = 1'b0;
          err_nxt     = 1'b1;
          state_nxt   = IDLE;
        end
      end

      ACK: begin
        if (fall) begin
          cnt_nxt = '0;
          if (data_lvl) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_IDLE;
          end
        end else if (timed_out) begin
          data_oe_nxt = 1'b0;
          err_nxt     = 1'b1;
          state_nxt   = IDLE;
        end
      end

      WAIT_IDLE: begin
        if (clk_lvl && data_lvl) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (fall) begin
          cnt_nxt = '0;
        end else if (timed_out) begin
          data_oe_nxt = 1'b0;
          err_nxt     = 1'b1;
          state_nxt   = IDLE;
        end
      end

      default: begin
        data_oe_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  assign bus.ps2_clk_oe  = (state == INHIBIT);
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.tx_busy     = (state != IDLE);
  assign bus.tx_done     = done_q;
  assign bus.tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx against a behavioural PS/2 keyboard on open-drain lines.
// With PS2_TX_FILTER_EN defined an extra step injects a short clock glitch.
module tb_ps2_host_tx;

  localparam int INHIBIT_CYC  = 50;
  localparam int TIMEOUT_CYC  = 1500;
  localparam int HALF         = 20;
  localparam int FRAME_BUDGET = 2000;

  typedef enum logic [1:0] {EXP_DONE, EXP_NOACK, EXP_TIMEOUT} kind_t;
  typedef struct {
    logic [7:0] data;
    kind_t      kind;
  } exp_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  ps2_host_tx_if #(.WIDTH(8)) bus ();

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch_low   = 1'b0;

  assign bus.ps2_key_clk  = ~(bus.ps2_clk_oe | dev_clk_low | glitch_low);
  assign bus.ps2_key_data = ~(bus.ps2_data_oe | dev_data_low);

  always #5 sys_clk = ~sys_clk;

  ps2_host_tx #(
    .WIDTH      (8),
    .INHIBIT_CYC(INHIBIT_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  int   cyc         = 0;
  int   done_cnt    = 0;
  int   err_cnt     = 0;
  int   both_cnt    = 0;
  int   run_len     = 0;
  int   inhibit_len = 0;
  int   req_cyc     = 0;
  int   err_cyc     = 0;
  logic clk_oe_prev = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse counters and inhibit-length / request-to-error timing taps
  always @(negedge sys_clk) begin
    if (bus.tx_done) done_cnt <= done_cnt + 1;
    if (bus.tx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (bus.tx_done && bus.tx_err) both_cnt <= both_cnt + 1;
    if (bus.ps2_clk_oe) begin
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      inhibit_len <= run_len;
      run_len     <= 0;
    end
    if (clk_oe_prev && !bus.ps2_clk_oe) req_cyc <= cyc;
    clk_oe_prev <= bus.ps2_clk_oe;
  end

  logic        dev_en     = 1'b1;
  logic        dev_ack    = 1'b1;
  logic        dev_abort  = 1'b0;
  logic        dev_glitch = 1'b0;
  int          dev_falls  = 0;
  logic [10:0] rx_q[$];

  task automatic dev_wait(input int n);
    for (int i = 0; i < n && !dev_abort; i++) @(negedge sys_clk);
  endtask

  // Keyboard side: 11 clocks, samples on rising edges, ACK low before falling edge 11
  task automatic dev_frame();
    logic [10:0] bits;
    bits      = '0;
    bits[0]   = bus.ps2_key_data;
    dev_falls = 0;
    for (int k = 1; k <= 11 && !dev_abort; k++) begin
      dev_wait(HALF / 2);
      if (k == 3 && dev_glitch) begin
        #4 glitch_low = 1'b1;
        #2 glitch_low = 1'b0;
      end
      if (k == 11 && dev_ack) dev_data_low = 1'b1;
      dev_wait(HALF - HALF / 2);
      dev_clk_low = 1'b1;
      dev_falls   = k;
      dev_wait(HALF);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = bus.ps2_key_data;
      if (k == 10 && !dev_abort) rx_q.push_back(bits);
    end
    dev_wait(HALF);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge sys_clk);
      if (dev_en && bus.ps2_clk_oe) begin
        while (bus.ps2_clk_oe && !dev_abort) @(negedge sys_clk);
        if (!dev_abort && bus.ps2_data_oe) dev_frame();
      end
    end
  end

  exp_t exp_q[$];

  function automatic logic odd_parity(input logic [7:0] d);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return (n % 2) == 0;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, req);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input kind_t kind);
    exp_t e;
    e.data = data;
    e.kind = kind;
    exp_q.push_back(e);
    @(negedge sys_clk);
    bus.tx_data  = data;
    bus.tx_start = 1'b1;
    @(negedge sys_clk);
    bus.tx_start = 1'b0;
    check_bit("clk_oe_after_start", bus.ps2_clk_oe, 1'b1);
    check_bit("busy_after_start", bus.tx_busy, 1'b1);
  endtask

  task automatic wait_result(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge sys_clk);
      seen = bus.tx_done | bus.tx_err;
    end
  endtask

  task automatic check_output();
    exp_t        e;
    logic        seen;
    logic [10:0] f;
    int          d0;
    int          e0;
    d0 = done_cnt;
    e0 = err_cnt;
    e  = exp_q.pop_front();
    wait_result((e.kind == EXP_TIMEOUT) ? TIMEOUT_CYC + 200 : FRAME_BUDGET, seen);
    check_bit("result_seen", seen, 1'b1);
    check_bit("clk_released_at_end", bus.ps2_clk_oe, 1'b0);
    check_bit("data_released_at_end", bus.ps2_data_oe, 1'b0);
    check_bit("busy_low_at_pulse", bus.tx_busy, 1'b0);
    repeat (4) @(negedge sys_clk);
    check_int("done_pulses", done_cnt - d0, (e.kind == EXP_DONE) ? 1 : 0);
    check_int("err_pulses", err_cnt - e0, (e.kind == EXP_DONE) ? 0 : 1);
    check_int("inhibit_len", inhibit_len, INHIBIT_CYC);
    if (e.kind == EXP_TIMEOUT) begin
      check_int("timeout_cycles", err_cyc - req_cyc, TIMEOUT_CYC);
    end else begin
      check_int("rx_frames", rx_q.size(), 1);
      if (rx_q.size() != 0) begin
        f = rx_q.pop_front();
        check_int("rx_byte", int'(f[8:1]), int'(e.data));
        check_bit("rx_start", f[0], 1'b0);
        check_bit("rx_parity", f[9], odd_parity(e.data));
        check_bit("rx_stop", f[10], 1'b1);
      end
    end
    repeat (4 * HALF) @(negedge sys_clk);
  endtask

  initial begin
    exp_t drop;
    int   d0;
    int   e0;
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_bit("reset_clk_oe", bus.ps2_clk_oe, 1'b0);
    check_bit("reset_data_oe", bus.ps2_data_oe, 1'b0);
    check_bit("reset_busy", bus.tx_busy, 1'b0);
    check_bit("reset_done", bus.tx_done, 1'b0);
    check_bit("reset_err", bus.tx_err, 1'b0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    $display("[TB] step: 0xF4 with ACK");
    apply_stimulus(8'hF4, EXP_DONE);
    check_output();

    $display("[TB] step: 0xED with ACK");
    apply_stimulus(8'hED, EXP_DONE);
    check_output();

    $display("[TB] step: missing ACK");
    dev_ack = 1'b0;
    apply_stimulus(8'h12, EXP_NOACK);
    check_output();
    dev_ack = 1'b1;

    $display("[TB] step: device never clocks");
    dev_en = 1'b0;
    apply_stimulus(8'h34, EXP_TIMEOUT);
    check_output();
    dev_en = 1'b1;

    $display("[TB] step: reset during bit 4");
    apply_stimulus(8'h0F, EXP_DONE);
    for (int i = 0; i < FRAME_BUDGET && dev_falls != 5; i++) @(negedge sys_clk);
    check_int("reached_bit4", dev_falls, 5);
    repeat ((HALF * 3) / 4) @(negedge sys_clk);
    check_bit("bit4_driven_low", bus.ps2_data_oe, 1'b1);
    d0 = done_cnt;
    e0 = err_cnt;
    #2;
    sys_rst_n = 1'b0;
    dev_abort = 1'b1;
    #1;
    check_bit("async_rst_clk_oe", bus.ps2_clk_oe, 1'b0);
    check_bit("async_rst_data_oe", bus.ps2_data_oe, 1'b0);
    check_bit("async_rst_busy", bus.tx_busy, 1'b0);
    drop = exp_q.pop_back();
    repeat (3 * HALF) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    dev_abort = 1'b0;
    repeat (4) @(negedge sys_clk);
    check_int("rst_no_done", done_cnt - d0, 0);
    check_int("rst_no_err", err_cnt - e0, 0);
    check_int("rst_no_frame", rx_q.size(), 0);
    apply_stimulus(8'h00, EXP_DONE);
    check_output();

    $display("[TB] step: start while busy is ignored");
    apply_stimulus(8'h55, EXP_DONE);
    repeat (200) @(negedge sys_clk);
    check_bit("busy_mid_frame", bus.tx_busy, 1'b1);
    bus.tx_data  = 8'hAA;
    bus.tx_start = 1'b1;
    @(negedge sys_clk);
    bus.tx_start = 1'b0;
    check_output();
    repeat (200) @(negedge sys_clk);
    check_bit("no_second_transfer", bus.tx_busy, 1'b0);
    check_int("no_extra_frame", rx_q.size(), 0);

`ifdef PS2_TX_FILTER_EN
    $display("[TB] step: clock glitch rejected");
    dev_glitch = 1'b1;
    apply_stimulus(8'h3C, EXP_DONE);
    check_output();
    dev_glitch = 1'b0;
`endif

    check_int("done_err_overlap", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
